// File: rtl/rx_crc_deframe_if.sv
// Byte stream bundle for the RX deframer:
// received bytes in, stripped payload out.
interface rx_crc_deframe_if;
  logic [7:0] i_data_in;
  logic       i_data_valid;
  logic [7:0] o_data_out;
  logic       o_data_valid;
  logic       o_sof;
  logic       o_eof;

  modport master (
    output i_data_in,
    output i_data_valid,
    input  o_data_out,
    input  o_data_valid,
    input  o_sof,
    input  o_eof
  );

  modport slave (
    input  i_data_in,
    input  i_data_valid,
    output o_data_out,
    output o_data_valid,
    output o_sof,
    output o_eof
  );
endinterface

// File: rtl/rx_crc_deframe.sv
// RX deframer: parses and validates the 21-byte header,
// strips it and forwards the payload with SOF/EOF.
module rx_crc_deframe #(
  parameter logic [47:0] LOCAL_ADDR = 48'hFFFF_FFFF_FFFF,
  parameter logic [7:0]  INFO_TYPE  = 8'h04,
  parameter logic [15:0] MAX_LEN    = 16'd2048,
  parameter logic [15:0] TIMEOUT    = 16'd64
) (
  input  logic            i_clk163m84,
  input  logic            i_rst_n,
  rx_crc_deframe_if.slave s,
  output logic [7:0]      o_info_unit_idenf,
  output logic [15:0]     o_info_unit_leng,
  output logic            o_frame_ok,
  output logic            o_frame_err,
  output logic [3:0]      o_err_code,
  output logic [15:0]     o_frame_cnt,
  output logic [15:0]     o_err_cnt
);
  typedef enum logic [2:0] {
    IDLE, HDR, PAYLOAD, DROP, WAIT_LOW
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d, idx;
  logic [15:0] fram_q, fram_d;
  logic [7:0]  lhi_q, lhi_d;
  logic [39:0] dst_q, dst_d;
  logic [7:0]  hid_q, hid_d;
  logic [7:0]  uhi_q, uhi_d;
  logic [15:0] pay_q, pay_d;
  logic [15:0] idle_q, idle_d, idle_nx;
  logic        first_q, first_d;
  logic [7:0]  dout_q, dout_d;
  logic        dv_q, dv_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [3:0]  code_q, code_d, fcode;
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic [7:0]  id_q, id_d;
  logic [15:0] ulen_q, ulen_d;
  logic [15:0] unit;
  logic [47:0] dst_full;
  logic [7:0]  din;
  logic        vin, fail, tmo;

  assign din      = s.i_data_in;
  assign vin      = s.i_data_valid;
  assign idx      = cnt_q + 5'd1;
  assign unit     = {uhi_q, din};
  assign dst_full = {dst_q, din};
  assign idle_nx  = idle_q + 16'd1;
  assign tmo      = idle_nx >= TIMEOUT;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fram_d  = fram_q;
    lhi_d   = lhi_q;
    dst_d   = dst_q;
    hid_d   = hid_q;
    uhi_d   = uhi_q;
    pay_d   = pay_q;
    idle_d  = idle_q;
    first_d = first_q;
    dout_d  = 8'h00;
    dv_d    = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    id_d    = id_q;
    ulen_d  = ulen_q;
    fail    = 1'b0;
    fcode   = 4'd0;
    unique case (state_q)
      IDLE: begin
        idle_d = '0;
        if (vin) begin
          cnt_d = 5'd1;
          if (din != INFO_TYPE) begin
            fail  = 1'b1;
            fcode = 4'd1;
          end else begin
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (vin) begin
          idle_d = '0;
          cnt_d  = idx;
          case (idx)
            5'd2: if (din != 8'h00) begin
              fail  = 1'b1;
              fcode = 4'd2;
            end
            5'd3: fram_d[15:8] = din;
            5'd4: fram_d[7:0]  = din;
            5'd5: lhi_d        = din;
            5'd6: if (fram_q != {lhi_q, din}) begin
              fail  = 1'b1;
              fcode = 4'd3;
            end
            5'd13, 5'd14, 5'd15,
            5'd16, 5'd17: dst_d = dst_full[39:0];
            5'd18: begin
              dst_d = dst_full[39:0];
              if (dst_full != LOCAL_ADDR &&
                  dst_full != '1) begin
                fail  = 1'b1;
                fcode = 4'd4;
              end
            end
            5'd19: hid_d = din;
            5'd20: uhi_d = din;
            5'd21: begin
              // 17-bit sum so unit_leng near 16'hFFFF cannot alias
              if ({1'b0, unit} + 17'd15 !=
                  {1'b0, fram_q}) begin
                fail  = 1'b1;
                fcode = 4'd3;
              end else if (unit > MAX_LEN) begin
                fail  = 1'b1;
                fcode = 4'd5;
              end else begin
                id_d   = hid_q;
                ulen_d = unit;
                if (unit == 16'd0) begin
                  ok_d    = 1'b1;
                  fcnt_d  = fcnt_q + 16'd1;
                  state_d = WAIT_LOW;
                end else begin
                  pay_d   = unit;
                  first_d = 1'b1;
                  state_d = PAYLOAD;
                end
              end
            end
            default: ;
          endcase
        end else if (tmo) begin
          fail  = 1'b1;
          fcode = 4'd6;
        end else begin
          idle_d = idle_nx;
        end
      end
      PAYLOAD: begin
        if (vin) begin
          idle_d  = '0;
          dout_d  = din;
          dv_d    = 1'b1;
          sof_d   = first_q;
          first_d = 1'b0;
          pay_d   = pay_q - 16'd1;
          if (pay_q == 16'd1) begin
            eof_d   = 1'b1;
            ok_d    = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            state_d = WAIT_LOW;
          end
        end else if (tmo) begin
          fail  = 1'b1;
          fcode = 4'd6;
        end else begin
          idle_d = idle_nx;
        end
      end
      DROP: begin
        if (!vin) state_d = IDLE;
      end
      WAIT_LOW: begin
        if (vin) begin
          fail  = 1'b1;
          fcode = 4'd7;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a timed-out frame has no trailing bytes left to drop
    if (fail) begin
      err_d   = 1'b1;
      code_d  = fcode;
      ecnt_d  = ecnt_q + 16'd1;
      state_d = (fcode == 4'd6) ? IDLE : DROP;
    end
  end

  always_ff @(posedge i_clk163m84 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fram_q  <= '0;
      lhi_q   <= '0;
      dst_q   <= '0;
      hid_q   <= '0;
      uhi_q   <= '0;
      pay_q   <= '0;
      idle_q  <= '0;
      first_q <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
      id_q    <= '0;
      ulen_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fram_q  <= fram_d;
      lhi_q   <= lhi_d;
      dst_q   <= dst_d;
      hid_q   <= hid_d;
      uhi_q   <= uhi_d;
      pay_q   <= pay_d;
      idle_q  <= idle_d;
      first_q <= first_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
      id_q    <= id_d;
      ulen_q  <= ulen_d;
    end
  end

  assign s.o_data_out       = dout_q;
  assign s.o_data_valid     = dv_q;
  assign s.o_sof            = sof_q;
  assign s.o_eof            = eof_q;
  assign o_frame_ok         = ok_q;
  assign o_frame_err        = err_q;
  assign o_err_code         = code_q;
  assign o_frame_cnt        = fcnt_q;
  assign o_err_cnt          = ecnt_q;
  assign o_info_unit_idenf  = id_q;
  assign o_info_unit_leng   = ulen_q;
endmodule

// File: tb/tb_rx_crc_deframe.sv
// Bench for rx_crc_deframe: frame-level model posts
// expected output events per clock edge; one checker compares.
module tb_rx_crc_deframe;
  localparam logic [47:0] L_ADDR = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic       dv;
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       ok;
    logic       err;
    logic [3:0] code;
    logic       hdr;
    logic [7:0] id;
    logic [15:0] len;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  o_idenf;
  logic [15:0] o_leng;
  logic        o_ok;
  logic        o_err;
  logic [3:0]  o_code;
  logic [15:0] o_fcnt;
  logic [15:0] o_ecnt;

  rx_crc_deframe_if bus ();

  rx_crc_deframe dut (
    .i_clk163m84       (clk),
    .i_rst_n           (rst_n),
    .s                 (bus),
    .o_info_unit_idenf (o_idenf),
    .o_info_unit_leng  (o_leng),
    .o_frame_ok        (o_ok),
    .o_frame_err       (o_err),
    .o_err_code        (o_code),
    .o_frame_cnt       (o_fcnt),
    .o_err_cnt         (o_ecnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  int n_chk = 0;
  int n_fail = 0;

  ev_t         ev [int];
  logic [7:0]  hb [21];
  logic [7:0]  pl [$];

  logic [15:0] m_fcnt, m_ecnt, m_len;
  logic [3:0]  m_code;
  logic [7:0]  m_id;
  ev_t         c_e;
  logic [72:0] c_act, c_exp;

  function automatic ev_t get(input int k);
    if (ev.exists(k)) return ev[k];
    return '0;
  endfunction

  task automatic lit(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input bit v,
                       input logic [7:0] b,
                       output int k);
    @(negedge clk);
    bus.i_data_valid = v;
    bus.i_data_in    = v ? b : 8'h00;
    k = pcnt + 1;
  endtask

  task automatic idle(input int n);
    int k;
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, k);
  endtask

  task automatic post_err(input int k,
                          input logic [3:0] c);
    ev_t e;
    e = get(k);
    e.err  = 1'b1;
    e.code = c;
    ev[k]  = e;
  endtask

  task automatic set_hdr(input logic [7:0]  typ,
                         input logic [15:0] fl,
                         input logic [15:0] ln,
                         input logic [47:0] dst,
                         input logic [7:0]  id,
                         input logic [15:0] ul);
    hb[0] = typ;
    hb[1] = 8'h00;
    hb[2] = fl[15:8];
    hb[3] = fl[7:0];
    hb[4] = ln[15:8];
    hb[5] = ln[7:0];
    for (int i = 0; i < 6; i++) begin
      hb[6 + i]  = 8'hFF;
      hb[12 + i] = dst[47 - 8 * i -: 8];
    end
    hb[18] = id;
    hb[19] = ul[15:8];
    hb[20] = ul[7:0];
  endtask

  task automatic good(input logic [7:0] id,
                      input int n,
                      input logic [7:0] base);
    logic [15:0] u;
    u = 16'(n);
    set_hdr(8'h04, u + 16'd15, u + 16'd15,
            L_ADDR, id, u);
    pl.delete();
    for (int i = 0; i < n; i++)
      pl.push_back(base + i[7:0]);
  endtask

  // Frame-level model: outcome from header fields, then drive
  task automatic send_frame(input bit gaps,
                            input int trunc_after,
                            input bit trailer);
    int          eidx, k, last;
    logic [3:0]  ecode;
    logic [15:0] fl, ln, ul;
    logic [47:0] dst;
    ev_t         e;
    fl  = {hb[2], hb[3]};
    ln  = {hb[4], hb[5]};
    ul  = {hb[19], hb[20]};
    dst = {hb[12], hb[13], hb[14],
           hb[15], hb[16], hb[17]};
    eidx  = 0;
    ecode = 4'd0;
    if (hb[0] != 8'h04) begin
      eidx = 1; ecode = 4'd1;
    end else if (hb[1] != 8'h00) begin
      eidx = 2; ecode = 4'd2;
    end else if (fl != ln) begin
      eidx = 6; ecode = 4'd3;
    end else if (dst != L_ADDR && dst != '1) begin
      eidx = 18; ecode = 4'd4;
    end else if (32'(ul) + 32'd15 != 32'(fl)) begin
      eidx = 21; ecode = 4'd3;
    end else if (ul > 16'd2048) begin
      eidx = 21; ecode = 4'd5;
    end
    for (int i = 0; i < 21; i++) begin
      if (gaps && eidx == 0 && i > 0)
        idle(int'($urandom_range(0, 3)));
      drive(1'b1, hb[i], k);
      if (i + 1 == eidx) post_err(k, ecode);
      if (i == 20 && eidx == 0) begin
        e     = get(k);
        e.hdr = 1'b1;
        e.id  = hb[18];
        e.len = ul;
        e.ok  = (ul == 16'd0);
        ev[k] = e;
      end
    end
    if (eidx != 0) begin
      foreach (pl[j]) drive(1'b1, pl[j], k);
      idle(1);
      return;
    end
    last = pl.size() - 1;
    for (int j = 0; j < pl.size(); j++) begin
      if (j == trunc_after) begin
        for (int t = 0; t < 64; t++)
          drive(1'b0, 8'h00, k);
        post_err(k, 4'd6);
        idle(1);
        return;
      end
      if (gaps && j > 0)
        idle(int'($urandom_range(0, 3)));
      drive(1'b1, pl[j], k);
      e      = get(k);
      e.dv   = 1'b1;
      e.data = pl[j];
      e.sof  = (j == 0);
      e.eof  = (j == last);
      e.ok   = (j == last);
      ev[k]  = e;
    end
    if (trailer) begin
      drive(1'b1, 8'hEE, k);
      post_err(k, 4'd7);
    end
    idle(1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data_in    = 8'h00;
    repeat (n) @(negedge clk);
    lit("rst frame_cnt", 32'(o_fcnt), 32'd0);
    lit("rst err_cnt", 32'(o_ecnt), 32'd0);
    lit("rst err_code", 32'(o_code), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b1;
    bus.i_data_valid = 1'b0;
    bus.i_data_in    = 8'h00;
    m_fcnt = '0; m_ecnt = '0; m_len = '0;
    m_code = '0; m_id = '0;
    #1 rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          m_fcnt = '0; m_ecnt = '0; m_len = '0;
          m_code = '0; m_id = '0;
          c_exp  = '0;
        end else begin
          c_e = get(pcnt);
          if (c_e.ok) m_fcnt = m_fcnt + 16'd1;
          if (c_e.err) begin
            m_ecnt = m_ecnt + 16'd1;
            m_code = c_e.code;
          end
          if (c_e.hdr) begin
            m_id  = c_e.id;
            m_len = c_e.len;
          end
          c_exp = {c_e.dv ? c_e.data : 8'h00,
                   c_e.dv, c_e.sof, c_e.eof,
                   c_e.ok, c_e.err, m_code,
                   m_fcnt, m_ecnt, m_id, m_len};
        end
        c_act = {bus.o_data_out, bus.o_data_valid,
                 bus.o_sof, bus.o_eof, o_ok, o_err,
                 o_code, o_fcnt, o_ecnt,
                 o_idenf, o_leng};
        n_chk++;
        if (c_act !== c_exp) begin
          n_fail++;
          $display("FAIL cycle %0d outputs: got %h want %h",
                   pcnt, c_act, c_exp);
        end
      end
      begin
        repeat (3) @(negedge clk);
        lit("init frame_cnt", 32'(o_fcnt), 32'd0);
        lit("init err_code", 32'(o_code), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        good(8'h5A, 4, 8'hA1);
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("good idenf", 32'(o_idenf), 32'h5A);
        lit("good leng", 32'(o_leng), 32'd4);
        lit("good frame_cnt", 32'(o_fcnt), 32'd1);

        good(8'h33, 0, 8'h00);
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("zlen frame_cnt", 32'(o_fcnt), 32'd2);
        lit("zlen leng", 32'(o_leng), 32'd0);

        good(8'h21, 2, 8'h50);
        hb[0] = 8'h05;
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("badtype code", 32'(o_code), 32'd1);
        lit("badtype err_cnt", 32'(o_ecnt), 32'd1);
        good(8'h61, 3, 8'h30);
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("after bad frame_cnt", 32'(o_fcnt), 32'd3);

        good(8'h41, 4, 8'h10);
        hb[4] = 8'h00;
        hb[5] = 8'h14;
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("lenmm code", 32'(o_code), 32'd3);
        good(8'h42, 4, 8'h10);
        for (int i = 0; i < 6; i++)
          hb[12 + i] = 8'(i + 1);
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("dst code", 32'(o_code), 32'd4);
        good(8'h43, 1, 8'h10);
        hb[1] = 8'h01;
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("segm code", 32'(o_code), 32'd2);
        lit("segm err_cnt", 32'(o_ecnt), 32'd4);

        good(8'h51, 8, 8'hB0);
        send_frame(1'b0, 3, 1'b0);
        idle(2);
        lit("trunc code", 32'(o_code), 32'd6);
        lit("trunc err_cnt", 32'(o_ecnt), 32'd5);
        lit("trunc frame_cnt", 32'(o_fcnt), 32'd3);

        good(8'h71, 5, 8'hC0);
        send_frame(1'b1, -1, 1'b0);
        good(8'h72, 3, 8'hD0);
        send_frame(1'b1, -1, 1'b0);
        idle(2);
        lit("b2b frame_cnt", 32'(o_fcnt), 32'd5);
        good(8'h73, 2, 8'hE0);
        send_frame(1'b0, -1, 1'b1);
        idle(2);
        lit("trailer code", 32'(o_code), 32'd7);
        lit("trailer frame_cnt", 32'(o_fcnt), 32'd6);

        set_hdr(8'h04, 16'd2064, 16'd2064, L_ADDR,
                8'h81, 16'd2049);
        pl.delete();
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("maxlen+1 code", 32'(o_code), 32'd5);
        good(8'h82, 2048, 8'h00);
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("maxlen leng", 32'(o_leng), 32'd2048);
        lit("maxlen frame_cnt", 32'(o_fcnt), 32'd7);
        set_hdr(8'h04, 16'h000E, 16'h000E, L_ADDR,
                8'h83, 16'hFFFF);
        pl.delete();
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("wrap17 code", 32'(o_code), 32'd3);
        lit("wrap17 err_cnt", 32'(o_ecnt), 32'd8);

        good(8'h91, 1, 8'h77);
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("n1 frame_cnt", 32'(o_fcnt), 32'd8);

        good(8'hA0, 3, 8'h01);
        for (int i = 0; i < 7; i++)
          drive(1'b1, hb[i], k);
        do_reset(3);
        idle(2);
        good(8'hA1, 2, 8'h01);
        send_frame(1'b0, -1, 1'b0);
        idle(2);
        lit("post-rst frame_cnt", 32'(o_fcnt), 32'd1);
        lit("post-rst idenf", 32'(o_idenf), 32'hA1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
      end
    join
  end
endmodule
